// File: rtl/pipelined_cpa_if.sv
// Valid/ready operand and result channels of the pipelined carry-propagate adder.
// Master drives operands and consumes results; slave is the adder.
interface pipelined_cpa_if #(
  parameter int WIDTH = 13
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_overflow;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_overflow
  );
endinterface

// File: rtl/pipelined_cpa.sv
// Pipelined carry-propagate adder/subtractor, one carry segment per stage.
// Define CPA_SATURATE_EN to clamp out_sum to max/min signed on overflow.
module pipelined_cpa #(
  parameter int WIDTH  = 13,
  parameter int STAGES = 4
) (
  input logic            clk,
  input logic            rst_n,
  pipelined_cpa_if.slave bus
);

  localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int MSB  = WIDTH - 1;
  localparam int LAST = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ov;
  } beat_t;

  beat_t             beat_q [STAGES];
  beat_t             beat_d [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              adv;

  assign adv          = !vld_q[LAST] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    beat_t cur;
    logic  v;
    logic  c;
    logic  cin;
    int    p;
    cur   = '0;
    v     = 1'b0;
    c     = 1'b0;
    cin   = 1'b0;
    p     = 0;
    vld_d  = vld_q;
    beat_d = beat_q;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        p = (k > 0) ? k - 1 : 0;
        if (k == 0) begin
          v      = bus.in_valid;
          cur.a  = bus.in_a;
          cur.b  = bus.in_b ^ {WIDTH{bus.in_sub}};
          cur.s  = '0;
          cur.c  = bus.in_sub;
          cur.ov = 1'b0;
        end else begin
          v   = vld_q[p];
          cur = beat_q[p];
        end
        c = cur.c;
        // ripple only across this stage's slice; empty stages pass through
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= k * SEG && i < (k + 1) * SEG) begin
            cin      = c;
            cur.s[i] = cur.a[i] ^ cur.b[i] ^ c;
            c        = (cur.a[i] & cur.b[i])
                     | (c & (cur.a[i] ^ cur.b[i]));
            if (i == MSB) cur.ov = cin ^ c;
          end
        end
        cur.c = c;
`ifdef CPA_SATURATE_EN
        if (k == LAST && cur.ov) begin
          cur.s = cur.s[MSB] ? {1'b0, {(WIDTH-1){1'b1}}}
                             : {1'b1, {(WIDTH-1){1'b0}}};
        end
`else
`endif
        vld_d[k]  = v;
        beat_d[k] = cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // datapath flops carry no reset; outputs are gated by the valid bit
  always_ff @(posedge clk) begin
    beat_q <= beat_d;
  end

  assign bus.out_valid    = vld_q[LAST];
  assign bus.out_sum      = vld_q[LAST] ? beat_q[LAST].s : '0;
  assign bus.out_cout     = vld_q[LAST] & beat_q[LAST].c;
  assign bus.out_overflow = vld_q[LAST] & beat_q[LAST].ov;

endmodule

// File: tb/tb_pipelined_cpa.sv
// Bench for pipelined_cpa: directed table, stall/random streams, reset, sweeps.
// Expected values come from a plain-arithmetic reference model.
module tb_pipelined_cpa;

`ifdef CPA_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int NSW = 256 * 16 * 2;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } sb_t;

  typedef struct {
    logic [12:0] a;
    logic [12:0] b;
    logic        sub;
    logic [12:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cpa_if #(.WIDTH(13)) bus ();
  pipelined_cpa_if #(.WIDTH(8))  b1 ();
  pipelined_cpa_if #(.WIDTH(8))  b3 ();
  pipelined_cpa_if #(.WIDTH(13)) b13 ();

  pipelined_cpa #(.WIDTH(13), .STAGES(4))  dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipelined_cpa #(.WIDTH(8),  .STAGES(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  pipelined_cpa #(.WIDTH(8),  .STAGES(3))  u3  (.clk(clk), .rst_n(rst_n), .bus(b3));
  pipelined_cpa #(.WIDTH(13), .STAGES(13)) u13 (.clk(clk), .rst_n(rst_n), .bus(b13));

  sb_t q1[$];
  sb_t q3[$];
  sb_t q13[$];
  int  err[3];
  int  cnt[3];

  function automatic res_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic sub);
    res_t r;
    longint unsigned m, full, bb, aa;
    logic sa, sb, ss;
    m    = (64'd1 << w) - 1;
    aa   = {32'd0, a} & m;
    bb   = {32'd0, b} & m;
    if (sub) bb = m - bb;
    full = aa + bb + {63'd0, sub};
    r.sum  = 32'(full & m);
    r.cout = full[w];
    sa = a[w-1];
    sb = b[w-1];
    ss = r.sum[w-1];
    r.ovf = sub ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    if (SAT && r.ovf)
      r.sum = sa ? 32'(64'd1 << (w - 1)) : 32'(m >> 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_one(input vec_t v, input int idx);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_sub   = v.sub;
    while (1) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        bus.in_valid = 1'b0;
        bus.in_a     = 'x;
        bus.in_b     = 'x;
        bus.in_sub   = 1'bx;
      end
      if (bus.out_valid || n >= 20) break;
    end
    chk($sformatf("vec%0d_lat", idx), 32'(n), 32'd4);
    chk($sformatf("vec%0d_sum", idx), 32'(bus.out_sum), 32'(v.sum));
    chk($sformatf("vec%0d_cout", idx), 32'(bus.out_cout), 32'(v.cout));
    chk($sformatf("vec%0d_ovf", idx), 32'(bus.out_overflow), 32'(v.ovf));
  endtask

  task automatic run_stream(input int nbeats, input bit rnd, input int lo,
                            input int hi, input string tag);
    res_t        q[$];
    res_t        e;
    logic [12:0] ca, cb;
    logic        cs;
    logic [15:0] hv;
    bit          held;
    int          sent, got, c;
    sent = 0; got = 0; c = 0; held = 0; hv = '0;
    ca = 13'($urandom); cb = 13'($urandom); cs = 1'($urandom);
    while (got < nbeats && c < nbeats * 10 + 40) begin
      @(negedge clk);
      c++;
      if (held)
        chk({tag, "_stable"},
            32'({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_overflow}),
            32'(hv));
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(c >= lo && c <= hi);
      if (sent < nbeats && (!rnd || $urandom_range(0, 3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_a = ca; bus.in_b = cb; bus.in_sub = cs;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_a = 'x; bus.in_b = 'x; bus.in_sub = 1'bx;
      end
      #1;
      chk({tag, "_in_ready"}, 32'(bus.in_ready),
          32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk({tag, "_unexpected_beat"}, 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk($sformatf("%s_beat%0d", tag, got),
              32'({bus.out_sum, bus.out_cout, bus.out_overflow}),
              32'({e.sum[12:0], e.cout, e.ovf}));
        end
        got++;
      end
      held = bus.out_valid && !bus.out_ready;
      hv = {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_overflow};
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(13, 32'(ca), 32'(cb), cs));
        sent++;
        ca = 13'($urandom); cb = 13'($urandom); cs = 1'($urandom);
      end
    end
    chk({tag, "_count"}, 32'(got), 32'(nbeats));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic sw_mon(input int cfg, input int st, input logic v,
                        input logic [12:0] s, input logic co, input logic ov);
    sb_t e;
    bit  empty;
    if (!v) return;
    cnt[cfg]++;
    empty = (cfg == 0) ? (q1.size() == 0) :
            (cfg == 1) ? (q3.size() == 0) : (q13.size() == 0);
    if (empty) begin
      err[cfg]++;
      return;
    end
    if (cfg == 0)      e = q1.pop_front();
    else if (cfg == 1) e = q3.pop_front();
    else               e = q13.pop_front();
    if ({s, co, ov} !== {e.r.sum[12:0], e.r.cout, e.r.ovf} || cyc - e.acc != st)
      err[cfg]++;
  endtask

  vec_t        vt[7];
  logic [7:0]  btab[16];
  logic [12:0] ra, rb;
  logic        rs;
  bit          stale;

  initial begin
    vt[0] = '{13'h0FFF, 13'h0001, 1'b0, SAT ? 13'h0FFF : 13'h1000, 1'b0, 1'b1};
    vt[1] = '{13'h1FFF, 13'h0001, 1'b0, 13'h0000, 1'b1, 1'b0};
    vt[2] = '{13'h0000, 13'h0001, 1'b1, 13'h1FFF, 1'b0, 1'b0};
    vt[3] = '{13'h1000, 13'h0001, 1'b1, SAT ? 13'h1000 : 13'h0FFF, 1'b1, 1'b1};
    vt[4] = '{13'h0AAA, 13'h0555, 1'b0, 13'h0FFF, 1'b0, 1'b0};
    vt[5] = '{13'h1000, 13'h1000, 1'b0, SAT ? 13'h1000 : 13'h0000, 1'b1, 1'b1};
    vt[6] = '{13'h0123, 13'h0123, 1'b1, 13'h0000, 1'b1, 1'b0};
    btab = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'hFE,
             8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 12; i < 16; i++) btab[i] = 8'($urandom);
    err = '{0, 0, 0};
    cnt = '{0, 0, 0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
    b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    b1.in_a = '0; b1.in_b = '0; b1.in_sub = 1'b0;
    b3.in_valid = 1'b0; b3.out_ready = 1'b1;
    b3.in_a = '0; b3.in_b = '0; b3.in_sub = 1'b0;
    b13.in_valid = 1'b0; b13.out_ready = 1'b1;
    b13.in_a = '0; b13.in_b = '0; b13.in_sub = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_flags", 32'({bus.out_cout, bus.out_overflow}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) send_one(vt[i], i);
    @(posedge clk); #1;
    chk("idle_no_x", 32'({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_overflow}),
        32'd0);

    run_stream(8, 1'b0, 6, 8, "stall");
    run_stream(200, 1'b1, -1, -1, "rand");

    // fill the pipe against a stalled consumer, then reset mid-cycle
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_a = 13'($urandom); bus.in_b = 13'($urandom); bus.in_sub = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_outs", 32'({bus.out_sum, bus.out_cout, bus.out_overflow}), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1;
    end
    chk("no_stale_beat", 32'(stale), 32'd0);
    send_one(vt[1], 11);

    // parallel sweep of alternate geometries
    for (int j = 0; j < NSW + 20; j++) begin
      @(negedge clk);
      if (j < NSW) begin
        b1.in_valid = 1'b1; b3.in_valid = 1'b1; b13.in_valid = 1'b1;
        b1.in_a = 8'(j % 256); b1.in_b = btab[(j / 256) % 16];
        b1.in_sub = 1'(j / 4096);
        b3.in_a = b1.in_a; b3.in_b = b1.in_b; b3.in_sub = b1.in_sub;
        ra = 13'($urandom); rb = 13'($urandom); rs = 1'($urandom);
        b13.in_a = ra; b13.in_b = rb; b13.in_sub = rs;
      end else begin
        b1.in_valid = 1'b0; b3.in_valid = 1'b0; b13.in_valid = 1'b0;
      end
      #1;
      sw_mon(0, 1, b1.out_valid, {5'd0, b1.out_sum}, b1.out_cout, b1.out_overflow);
      sw_mon(1, 3, b3.out_valid, {5'd0, b3.out_sum}, b3.out_cout, b3.out_overflow);
      sw_mon(2, 13, b13.out_valid, b13.out_sum, b13.out_cout, b13.out_overflow);
      if (b1.in_valid && b1.in_ready)
        q1.push_back('{model(8, 32'(b1.in_a), 32'(b1.in_b), b1.in_sub), cyc});
      if (b3.in_valid && b3.in_ready)
        q3.push_back('{model(8, 32'(b3.in_a), 32'(b3.in_b), b3.in_sub), cyc});
      if (b13.in_valid && b13.in_ready)
        q13.push_back('{model(13, 32'(b13.in_a), 32'(b13.in_b), b13.in_sub), cyc});
    end
    chk("sweep_s1_err", 32'(err[0]), 32'd0);
    chk("sweep_s1_cnt", 32'(cnt[0]), 32'(NSW));
    chk("sweep_s3_err", 32'(err[1]), 32'd0);
    chk("sweep_s3_cnt", 32'(cnt[1]), 32'(NSW));
    chk("sweep_s13_err", 32'(err[2]), 32'd0);
    chk("sweep_s13_cnt", 32'(cnt[2]), 32'(NSW));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
